// File: rtl/aec_pkg.sv
// Shared types and constants for the calculator-result ASCII formatter.
// Holds the formatter FSM states, ASCII codes and the digit-buffer depth.
package aec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SIGN,
    ST_DIGIT,
    ST_TERM
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // 2^32-1 has ten decimal digits
  localparam int DIG_DEPTH = 10;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'b0000, d};
  endfunction

endpackage

// File: rtl/aec_div10.sv
// Serial restoring divide-by-10: one quotient bit per cycle, done pulses 32 cycles after start.
// The first bit is resolved on the start edge itself, so back-to-back divisions cost 32 cycles each.
module aec_div10 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        done,
  output logic [31:0] quotient,
  output logic [3:0]  remainder
);

  logic [31:0] shreg;
  logic [3:0]  rem;
  logic [4:0]  cnt;
  logic        run;

  logic [3:0]  cur_rem;
  logic        cur_bit;
  logic [4:0]  trial;
  logic        qbit;
  logic [3:0]  next_rem;

  // shreg shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    cur_rem  = start ? 4'd0 : rem;
    cur_bit  = start ? dividend[31] : shreg[31];
    trial    = {cur_rem, cur_bit};
    qbit     = (trial >= 5'd10);
    next_rem = qbit ? 4'(trial - 5'd10) : trial[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= 32'd0;
      rem   <= 4'd0;
      cnt   <= 5'd0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg <= {dividend[30:0], qbit};
        rem   <= next_rem;
        cnt   <= 5'd1;
        run   <= 1'b1;
      end else if (run) begin
        shreg <= {shreg[30:0], qbit};
        rem   <= next_rem;
        cnt   <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = shreg;
  assign remainder = rem;

endmodule

// File: rtl/aec_result_fmt.sv
// Converts a 32-bit calculator result into an ASCII decimal byte stream ('-', digits MSD first, terminator)
// over a valid/ready port; completions arriving while busy are dropped and flagged in a sticky overrun.
module aec_result_fmt #(
  parameter int         SIGNED = 1,
  parameter logic [7:0] TERM   = 8'h0A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        finish,
  input  logic [31:0] result,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        overrun,
  input  logic        clr_overrun
);

  import aec_pkg::*;

  state_t      state;
  logic        finish_q;
  logic        neg;
  logic [31:0] mag;
  logic        first;
  logic [3:0]  ndig;
  logic [3:0]  idx;
  logic [3:0]  dig_buf [DIG_DEPTH];

  logic        completion;
  logic        capture;
  logic        res_neg;
  logic [31:0] res_mag;
  logic        hs;
  logic        div_start;
  logic [31:0] div_dividend;
  logic        div_done;
  logic [31:0] div_quot;
  logic [3:0]  div_rem;

  always_comb begin
    completion   = finish && !finish_q;
    capture      = completion && (state == ST_IDLE);
    res_neg      = (SIGNED != 0) && result[31];
    res_mag      = res_neg ? (32'd0 - result) : result;
    hs           = out_valid && out_ready;
    // the first division starts the cycle after capture; later ones chain on the previous quotient
    div_start    = (state == ST_CONV) && (first || (div_done && (div_quot != 32'd0)));
    div_dividend = first ? mag : div_quot;
  end

  aec_div10 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (div_dividend),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      finish_q  <= 1'b1;
      neg       <= 1'b0;
      mag       <= 32'd0;
      first     <= 1'b0;
      ndig      <= 4'd0;
      idx       <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < DIG_DEPTH; i++) dig_buf[i] <= 4'd0;
    end else begin
      finish_q <= finish;

      // a fresh drop wins over a simultaneous clear
      if (completion && (state != ST_IDLE)) overrun <= 1'b1;
      else if (clr_overrun)                 overrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (capture) begin
            neg   <= res_neg;
            mag   <= res_mag;
            first <= 1'b1;
            ndig  <= 4'd0;
            busy  <= 1'b1;
            state <= ST_CONV;
          end
        end

        ST_CONV: begin
          first <= 1'b0;
          if (div_done) begin
            dig_buf[ndig] <= div_rem;
            ndig          <= ndig + 4'd1;
            if (div_quot == 32'd0) begin
              idx       <= ndig;
              out_valid <= 1'b1;
              if (neg) begin
                out_data <= ASCII_MINUS;
                state    <= ST_SIGN;
              end else begin
                out_data <= digit_char(div_rem);
                state    <= ST_DIGIT;
              end
            end
          end
        end

        ST_SIGN: begin
          if (hs) begin
            out_data <= digit_char(dig_buf[idx]);
            state    <= ST_DIGIT;
          end
        end

        ST_DIGIT: begin
          if (hs) begin
            if (idx == 4'd0) begin
              out_data <= TERM;
              state    <= ST_TERM;
            end else begin
              idx      <= idx - 4'd1;
              out_data <= digit_char(dig_buf[idx - 4'd1]);
            end
          end
        end

        ST_TERM: begin
          if (hs) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aec_result_fmt.sv
// Bench for aec_result_fmt: a signed and an unsigned instance share stimulus and are
// compared against a decimal-string reference model, byte stream and first-valid latency.
module tb_aec_result_fmt;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst;
  logic        finish;
  logic [31:0] result;
  logic        clr_overrun;
  logic        rdy [2];

  logic        vld_s, vld_u, bsy_s, bsy_u, ovr_s, ovr_u;
  logic [7:0]  dat_s, dat_u;
  logic        vld [2];
  logic        bsy [2];
  logic        ovr [2];
  logic [7:0]  dat [2];

  logic [7:0]  got [2][$];
  int          lat [2];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  aec_result_fmt #(.SIGNED(1), .TERM(8'h0A)) u_dut_s (
    .clk(clk), .rst(rst), .finish(finish), .result(result),
    .out_valid(vld_s), .out_data(dat_s), .out_ready(rdy[0]),
    .busy(bsy_s), .overrun(ovr_s), .clr_overrun(clr_overrun)
  );

  aec_result_fmt #(.SIGNED(0), .TERM(8'h0A)) u_dut_u (
    .clk(clk), .rst(rst), .finish(finish), .result(result),
    .out_valid(vld_u), .out_data(dat_u), .out_ready(rdy[1]),
    .busy(bsy_u), .overrun(ovr_u), .clr_overrun(clr_overrun)
  );

  assign vld[0] = vld_s;
  assign vld[1] = vld_u;
  assign bsy[0] = bsy_s;
  assign bsy[1] = bsy_u;
  assign ovr[0] = ovr_s;
  assign ovr[1] = ovr_u;
  assign dat[0] = dat_s;
  assign dat[1] = dat_u;

  // Expected text: optional '-', decimal digits MSD first, then LF.
  function automatic bq_t model(input logic [31:0] v, input bit sgn);
    bq_t q;
    bq_t d;
    longint unsigned m;
    if (sgn && v[31]) begin
      q.push_back(8'h2D);
      m = 64'h1_0000_0000 - {32'd0, v};
    end else begin
      m = {32'd0, v};
    end
    do begin
      d.push_front(8'h30 + 8'(m % 10));
      m = m / 10;
    end while (m != 0);
    foreach (d[k]) q.push_back(d[k]);
    q.push_back(8'h0A);
    return q;
  endfunction

  function automatic int n_digits(input bq_t q);
    int n = 0;
    foreach (q[k]) if (q[k] >= 8'h30 && q[k] <= 8'h39) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [31:0] v, input bit stall, input int glitch_at, input bit glitch_clr);
    logic       pv [2];
    logic       pr [2];
    logic [7:0] pd [2];
    int         wcnt [2];
    bit         seen [2];
    bit         fin [2];
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pr[i] = 1'b0; pd[i] = 8'd0; wcnt[i] = 0;
      seen[i] = 1'b0; fin[i] = 1'b0; lat[i] = -1;
      got[i].delete();
      rdy[i] = 1'b0;
    end
    finish = 1'b0;
    tick;
    finish = 1'b1;
    result = v;
    for (int m = 0; m < 3000 && !(fin[0] && fin[1]); m++) begin
      tick;
      if (m == 0) begin
        chk("conv_valid_low", vld[0], 1'b0);
        chk("busy_set", bsy[0], 1'b1);
      end
      if (m == glitch_at) finish = 1'b0;
      if (m == glitch_at + 1) begin
        finish      = 1'b1;
        result      = 32'd999;
        clr_overrun = glitch_clr;
      end
      if (m == glitch_at + 2) clr_overrun = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && pr[i]) begin
          got[i].push_back(pd[i]);
          if (pd[i] == 8'h0A) begin
            fin[i] = 1'b1;
            chk("busy_after_term", bsy[i], 1'b0);
          end
        end else if (pv[i]) begin
          chk("hold_valid", vld[i], 1'b1);
          chk("hold_data", dat[i], pd[i]);
        end
        if (vld[i] && !seen[i]) begin
          seen[i] = 1'b1;
          lat[i]  = m;
        end
        if (!stall) begin
          rdy[i] = 1'b1;
        end else begin
          rdy[i] = vld[i] && (wcnt[i] >= 5);
          if (vld[i] && !rdy[i]) wcnt[i]++;
          else wcnt[i] = 0;
        end
        pv[i] = vld[i];
        pr[i] = rdy[i];
        pd[i] = dat[i];
      end
    end
    for (int i = 0; i < 2; i++) chk("term_seen", fin[i], 1'b1);
  endtask

  task automatic do_case(input string tag, input logic [31:0] v, input bit stall, input int g, input bit gc);
    bq_t e;
    bq_t gq;
    string t;
    run_txn(v, stall, g, gc);
    for (int i = 0; i < 2; i++) begin
      e  = model(v, i == 0);
      gq = got[i];
      t  = $sformatf("%s_%s", tag, (i == 0) ? "s" : "u");
      chk({t, "_len"}, gq.size(), e.size());
      for (int k = 0; k < e.size() && k < gq.size(); k++)
        chk($sformatf("%s_byte%0d", t, k), gq[k], e[k]);
      chk({t, "_latency"}, lat[i], 32 * n_digits(e) + 1);
    end
  endtask

  initial begin
    logic [31:0] v;
    bit          stall;
    bit          ok;
    bit          any;

    rst = 1'b1; finish = 1'b1; result = 32'd0; clr_overrun = 1'b0;
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", vld[i], 1'b0);
      chk("rst_data", dat[i], 8'h00);
      chk("rst_busy", bsy[i], 1'b0);
      chk("rst_overrun", ovr[i], 1'b0);
    end
    rst = 1'b0;
    repeat (3) tick;
    // finish is idle-high out of reset; that must not count as a completion
    for (int i = 0; i < 2; i++) begin
      chk("post_rst_busy", bsy[i], 1'b0);
      chk("post_rst_valid", vld[i], 1'b0);
    end

    do_case("dec123", 32'd123, 1'b0, -10, 1'b0);
    do_case("zero", 32'd0, 1'b0, -10, 1'b0);
    do_case("neg7", 32'hFFFF_FFF9, 1'b0, -10, 1'b0);
    do_case("minint", 32'h8000_0000, 1'b0, -10, 1'b0);
    do_case("stall45", 32'd45, 1'b1, -10, 1'b0);
    for (int i = 0; i < 2; i++) chk("no_overrun", ovr[i], 1'b0);

    do_case("ovr45", 32'd45, 1'b0, 10, 1'b0);
    for (int i = 0; i < 2; i++) chk("overrun_set", ovr[i], 1'b1);
    clr_overrun = 1'b1;
    tick;
    clr_overrun = 1'b0;
    for (int i = 0; i < 2; i++) chk("overrun_clr", ovr[i], 1'b0);

    do_case("ovrclr45", 32'd45, 1'b0, 10, 1'b1);
    for (int i = 0; i < 2; i++) chk("overrun_set_wins", ovr[i], 1'b1);
    clr_overrun = 1'b1;
    tick;
    clr_overrun = 1'b0;
    for (int i = 0; i < 2; i++) chk("overrun_clr2", ovr[i], 1'b0);

    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 2))
        0:       v = $urandom;
        1:       v = $urandom_range(0, 999);
        default: v = 32'd0 - $urandom_range(1, 100000);
      endcase
      stall = 1'($urandom_range(0, 1));
      do_case($sformatf("rand%0d", r), v, stall, -10, 1'b0);
    end

    // reset in the middle of the digit phase
    rdy[0] = 1'b0; rdy[1] = 1'b0;
    finish = 1'b0;
    tick;
    finish = 1'b1;
    result = 32'd987;
    ok = 1'b0;
    for (int m = 0; m < 500 && !ok; m++) begin
      tick;
      if (vld[0]) ok = 1'b1;
    end
    chk("rst_reach_valid", ok, 1'b1);
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    tick;
    tick;
    chk("rst_pre_data", dat[0], 8'h37);
    rst = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_valid", vld[i], 1'b0);
      chk("midrst_busy", bsy[i], 1'b0);
      chk("midrst_data", dat[i], 8'h00);
    end
    rst = 1'b0;
    any = 1'b0;
    repeat (150) begin
      tick;
      if (vld[0] || vld[1]) any = 1'b1;
    end
    chk("midrst_no_more_bytes", any, 1'b0);
    chk("midrst_idle", bsy[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
